mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler.sv | 150 +++++++++++++++
 tb/tb_mult_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_scheduler.sv
// -----------------------------------------------------------------------------
// mult_scheduler
//
// Two requesters share one sequential shift-add 4x4 unsigned multiplier.
// The arbiter is round-robin. A request is accepted in IDLE. The operands are
// then multiplied over four CALC cycles, one multiplier bit per cycle. The
// 8-bit product is held in DONE until the consumer takes it.
//
// Optional feature (compile-time macro):
//   MULT_SCHED_ZERO_SKIP_EN - if a == 0 or b == 0, the accepted request goes
//                             straight to DONE with a zero product.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   req0_valid/_a/_b/_ready  requester 0 operand pair and accept strobe
//   req1_valid/_a/_b/_ready  requester 1 operand pair and accept strobe
//   res_valid                product available (DONE)
//   res_data                 8-bit unsigned product
//   res_id                   requester that owns res_data
//   res_ready                consumer takes the result (ignored outside DONE)
//   busy                     high in any state other than IDLE
// -----------------------------------------------------------------------------
module mult_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;

  logic [3:0] a_q, b_q;     // latched operands of the in-flight request
  logic       id_q;         // owner of the in-flight request
  logic [7:0] acc_q;        // partial / final product
  logic [1:0] step_q;       // CALC step index (multiplier bit being added)
  logic       ptr_q;        // round-robin pointer: winner when both are valid

  logic       grant0, grant1;
  logic       accept;
  logic       grant_id;
  logic [3:0] sel_a, sel_b;
  logic       zero_op;
  logic [7:0] partial;

  // ---------------------------------------------------------------------------
  // Arbitration and next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first. This way no path
  // leaves a value unassigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;

    // Ready is gated by rst so no handshake can happen while reset is held.
    if (state == IDLE && !rst) begin
      grant0 = req0_valid & (~req1_valid | ~ptr_q);
      grant1 = req1_valid & (~req0_valid |  ptr_q);
    end

    accept   = grant0 | grant1;
    grant_id = grant1;

    unique case (state)
      IDLE:    if (accept)          state_nxt = zero_op ? DONE : CALC;
      CALC:    if (step_q == 2'd3)  state_nxt = DONE;
      DONE:    if (res_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  assign sel_a = grant1 ? req1_a : req0_a;
  assign sel_b = grant1 ? req1_b : req0_b;

`ifdef MULT_SCHED_ZERO_SKIP_EN
  // A zero operand makes the product zero, and the accumulator is cleared at
  // the handshake, so DONE can be entered at once.
  assign zero_op = (sel_a == 4'd0) | (sel_b == 4'd0);
`else
  assign zero_op = 1'b0;
`endif

  // Shifted multiplicand for the current step. It is widened before the
  // shift so no bits are lost; 15 << 3 still fits in 8 bits.
  assign partial = {4'b0000, a_q} << step_q;

  // ---------------------------------------------------------------------------
  // Control and accumulator registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr_q  <= 1'b0;
      id_q   <= 1'b0;
      acc_q  <= 8'd0;
      step_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_q   <= grant_id;
        acc_q  <= 8'd0;
        step_q <= 2'd0;
        ptr_q  <= ~grant_id;
      end else if (state == CALC) begin
        if (b_q[step_q]) acc_q <= acc_q + partial;
        step_q <= step_q + 2'd1;
      end
    end
  end

  // NOTE: the operand registers are not reset. They are always loaded at a
  // handshake before they are used, so a reset would only add fan-out on rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= sel_a;
      b_q <= sel_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == DONE);
  assign res_data   = acc_q;
  assign res_id     = id_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mult_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mult_scheduler
//
// Self-checking bench for mult_scheduler. The reference model is kept at
// transaction level:
//   - the product is a * b;
//   - grants follow round-robin arbitration;
//   - a result appears a fixed number of cycles after its handshake and stays
//     until it is consumed.
// All DUT outputs are compared against the model in every cycle. Directed
// sequences cover the listed scenarios, followed by a randomized sweep of all
// 256 operand pairs on each port.
// -----------------------------------------------------------------------------
module tb_mult_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  mult_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] b8(input logic x);
    return {7'd0, x};
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  // ---------------------------------------------------------------------------
  int         cyc      = 0;     // number of rising edges so far
  bit         known    = 0;     // DUT state defined (a reset edge was seen)
  bit         pend     = 0;     // a request is in flight or waiting in DONE
  int         ready_at = 0;     // first cycle in which the result is visible
  logic [7:0] exp_val;
  logic       exp_id;
  bit         ptr      = 0;
  bit         zero_out = 0;     // outputs must read zero (after reset)
  bit         acc0_f, acc1_f;   // model accepted port 0 / 1 at the last edge

  logic [8:0] got_q[$];         // {res_id, res_data} as taken by the consumer

  task automatic step(input logic r,
                      input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                      input logic rr);
    logic e0, e1, ev, skip;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready = rr;
    #1;
    e0 = !pend && !r && v0 && (!v1 || !ptr);
    e1 = !pend && !r && v1 && (!v0 ||  ptr);
    ev = pend && (cyc >= ready_at);
    if (known) begin
      check("req0_ready", b8(req0_ready), b8(e0));
      check("req1_ready", b8(req1_ready), b8(e1));
      check("busy",       b8(busy),       b8(pend));
      check("res_valid",  b8(res_valid),  b8(ev));
      if (ev) begin
        check("res_data", res_data,     exp_val);
        check("res_id",   b8(res_id),   b8(exp_id));
      end else if (zero_out) begin
        check("rst_data", res_data,     8'd0);
        check("rst_id",   b8(res_id),   8'd0);
      end
    end
    if (res_valid === 1'b1 && rr) got_q.push_back({res_id, res_data});

    @(posedge clk);
    cyc++;
    acc0_f = 0;
    acc1_f = 0;
    if (r) begin
      known = 1; pend = 0; ptr = 0; zero_out = 1;
    end else if (ev && rr) begin
      pend = 0;
    end else if (e0 || e1) begin
      pend     = 1;
      exp_id   = e1;
      exp_val  = e1 ? {4'd0, a1} * {4'd0, b1} : {4'd0, a0} * {4'd0, b0};
      ptr      = ~e1;
      zero_out = 0;
      acc0_f   = e0;
      acc1_f   = e1;
`ifdef MULT_SCHED_ZERO_SKIP_EN
      skip = e1 ? (a1 == 0 || b1 == 0) : (a0 == 0 || b0 == 0);
`else
      skip = 1'b0;
`endif
      ready_at = cyc + (skip ? 0 : 4);
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, rr);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int idx0, idx1, guard;
    logic [7:0] p0, p1;
    logic v0, v1;
    logic [3:0] a0, b0, a1, b1;

    rst = 1; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; res_ready = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'd3, 4'd3, 1, 4'd2, 4'd2, 1);   // valid while in reset: no ready
    idle(1, 1);

    // 15 * 15 on requester 0 alone
    n = got_q.size();
    step(0, 1, 4'd15, 4'd15, 0, 0, 0, 1);
    idle(7, 1);
    check("max_cnt",  8'(got_q.size() - n), 8'd1);
    if (got_q.size() > n) begin
      check("max_data", got_q[n][7:0],  8'hE1);
      check("max_id",   b8(got_q[n][8]), 8'd0);
    end

    // Both requesters held valid from reset: alternating grants
    step(1, 0, 0, 0, 0, 0, 0, 1);
    n = got_q.size();
    for (int i = 0; i < 30; i++) step(0, 1, 4'd3, 4'd5, 1, 4'd7, 4'd9, 1);
    idle(8, 1);
    check("rr_cnt", b8(got_q.size() >= n + 4), 8'd1);
    if (got_q.size() >= n + 4) begin
      check("rr0_data", got_q[n][7:0],       8'd15);
      check("rr0_id",   b8(got_q[n][8]),     8'd0);
      check("rr1_data", got_q[n+1][7:0],     8'd63);
      check("rr1_id",   b8(got_q[n+1][8]),   8'd1);
      check("rr2_id",   b8(got_q[n+2][8]),   8'd0);
      check("rr3_id",   b8(got_q[n+3][8]),   8'd1);
    end

    // Result 0x2A held for many cycles with res_ready low, requests pending
    step(0, 1, 4'd6, 4'd7, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 4'd1, 4'd1, 1, 4'd2, 4'd2, 0);
    n = got_q.size();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("hold_data", got_q.size() > n ? got_q[n][7:0] : 8'hFF, 8'h2A);
    idle(3, 1);

    // Reset in CALC step 2 discards the operation
    n = got_q.size();
    step(0, 1, 4'd9, 4'd9, 0, 0, 0, 1);
    idle(2, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(8, 1);
    check("abort_cnt", 8'(got_q.size() - n), 8'd0);

    // Zero operand on requester 1
    n = got_q.size();
    step(0, 0, 0, 0, 1, 4'd0, 4'd9, 1);
    idle(6, 1);
    check("zero_cnt", 8'(got_q.size() - n), 8'd1);
    if (got_q.size() > n) begin
      check("zero_data", got_q[n][7:0],   8'd0);
      check("zero_id",   b8(got_q[n][8]), 8'd1);
    end

    // Randomized sweep: all 256 pairs on each port, with random valid and
    // res_ready patterns, and garbage on the request inputs while busy.
    idx0 = 0; idx1 = 0; guard = 0;
    while ((idx0 < 256 || idx1 < 256 || pend) && guard < 20000) begin
      p0 = 8'(idx0);
      p1 = 8'((idx1 * 37 + 11) % 256);
      v0 = (idx0 < 256) && ($urandom_range(3) != 0);
      v1 = (idx1 < 256) && ($urandom_range(3) != 0);
      a0 = pend ? 4'($urandom) : p0[7:4];
      b0 = pend ? 4'($urandom) : p0[3:0];
      a1 = pend ? 4'($urandom) : p1[7:4];
      b1 = pend ? 4'($urandom) : p1[3:0];
      step(0, v0, a0, b0, v1, a1, b1, $urandom_range(2) != 0);
      if (acc0_f) idx0++;
      if (acc1_f) idx1++;
      guard++;
    end
    check("sweep_done", b8(idx0 == 256 && idx1 == 256 && !pend), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
